// File: rtl/uart_rx_port_if.sv
// UART receiver register/line bundle.
// Carries the serial input line, the core's clear strobe and the receiver's
// data/status registers between the core-side logic and uart_rx_port.
//   rx_serial      : serial line into the receiver (idles high)
//   rx_clear       : one-cycle strobe clearing the status flags
//   rx_data        : last good byte, zero-extended to DATA_WIDTH
//   rx_ready       : unread byte present
//   rx_frame_error : sticky, stop bit sampled low
//   rx_overrun     : sticky, byte completed while rx_ready was set
// master: core/bench side that drives the line and clear strobe.
// slave : the receiver peripheral.
interface uart_rx_port_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  rx_serial;
  logic                  rx_clear;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_ready;
  logic                  rx_frame_error;
  logic                  rx_overrun;

  modport master (
    output rx_serial,
    output rx_clear,
    input  rx_data,
    input  rx_ready,
    input  rx_frame_error,
    input  rx_overrun
  );

  modport slave (
    input  rx_serial,
    input  rx_clear,
    output rx_data,
    output rx_ready,
    output rx_frame_error,
    output rx_overrun
  );
endinterface

// File: rtl/uart_rx_port.sv
// Memory-mapped UART receiver (8N1).
// Samples the asynchronous rx_serial line through a two-flop synchronizer,
// finds the start bit, samples each data bit mid-bit (LSB first) and checks
// the stop bit. A good frame loads the byte register and raises rx_ready;
// a bad stop bit raises the sticky rx_frame_error. Completing a byte while
// rx_ready is still set raises the sticky rx_overrun. rx_clear drops all
// three flags but never touches the data register or the FSM.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-low reset
//   rx_bus : slave side of uart_rx_port_if (line, clear, data, flags)
module uart_rx_port #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_port_if.slave  rx_bus
);

  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(Half - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [1:0]      sync_q;
  logic            armed_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            ready_q;
  logic            ferr_q;
  logic            ovr_q;

  logic rx_s;
  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      sync_q    <= 2'b11;
      armed_q   <= 1'b0;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_bus.rx_serial};

      // Clear first so a same-cycle frame completion below takes priority.
      if (rx_bus.rx_clear) begin
        ready_q <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          // Only a high-to-low transition starts a frame; a held-low line
          // (break) must go high again before the next frame is accepted.
          if (rx_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            armed_q <= 1'b0;
            baud_q  <= '0;
            state_q <= StStart;
          end
        end

        StStart: begin
          if (baud_q == HalfEnd) begin
            baud_q <= '0;
            if (!rx_s) begin
              bit_idx_q <= 3'd0;
              state_q   <= StData;
            end else begin
              // Glitch shorter than half a bit: drop it silently.
              armed_q <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        StData: begin
          if (baud_q == BitEnd) begin
            baud_q             <= '0;
            shift_q[bit_idx_q] <= rx_s;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        StStop: begin
          if (baud_q == BitEnd) begin
            baud_q  <= '0;
            state_q <= StIdle;
            armed_q <= rx_s;
            if (rx_s) begin
              data_q  <= shift_q;
              ready_q <= 1'b1;
              if (ready_q && !rx_bus.rx_clear) begin
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign rx_bus.rx_data        = {{(DATA_WIDTH - 8){1'b0}}, data_q};
  assign rx_bus.rx_ready       = ready_q;
  assign rx_bus.rx_frame_error = ferr_q;
  assign rx_bus.rx_overrun     = ovr_q;

endmodule

// File: doc/uart_rx_port.md
Name: uart_rx_port

Overview:
- Memory-mapped UART receiver peripheral. Deserialises 8N1 frames from the external RX pin into a byte register.
- The core reads that register through the device read path, where the DEVICE_UART_RX select returns this block's data.
- Exposes ready, frame-error and overrun status flags. The core clears them with a single-cycle clear strobe.
- Sits beside the UART transmitter on the peripheral bus of the multicycle RISC-V.

Parameters:
- DATA_WIDTH, 32, width of the rx_data read word; the received byte is zero-extended into bits [7:0].
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200). Must be even and >= 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- rx_serial  input  1  asynchronous serial line; idles high.
- rx_clear  input  1  one-cycle strobe from the core; clears rx_ready, rx_frame_error and rx_overrun.
- rx_data  output  DATA_WIDTH  last good byte, zero-extended: {(DATA_WIDTH-8)'b0, byte}.
- rx_ready  output  1  a new byte is held in rx_data and has not been cleared.
- rx_frame_error  output  1  the last frame had its stop bit sampled low (sticky).
- rx_overrun  output  1  a byte completed while rx_ready was already 1 (sticky).

Behaviour:
- Reset (reset==0 at a clk edge):
  - rx_data=0, rx_ready=0, rx_frame_error=0, rx_overrun=0.
  - State=IDLE, bit counter=0, baud counter=0, shift register=0.
  - Synchronizer flops preset to 1.
  - Reset mid-frame aborts the frame; the partial byte is discarded.
- Synchronizer: rx_serial passes through 2 flops to give rx_s. All decisions use rx_s only.
- HALF = CLKS_PER_BIT/2.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if rx_s==0, go to START with baud counter=0.
  - START: count to HALF-1, then sample rx_s.
    - rx_s==0: go to DATA, baud counter=0, bit index=0.
    - rx_s==1: glitch; go back to IDLE with no flag change.
  - DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift[bit index] (LSB first) and increment bit index.
    - After bit 7 is sampled, go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s and go to IDLE in the same cycle.
    - rx_s==1: rx_data <= {0, shift}, rx_ready <= 1.
    - rx_s==0: rx_frame_error <= 1; rx_data and rx_ready are unchanged.
- Latency: rx_ready is visible 2 + HALF + 9*CLKS_PER_BIT + 1 cycles after the first clk edge that samples rx_serial low. The bench tolerates ±1.
- Back-to-back frames: the receiver is in IDLE from mid-stop-bit onward, so a start bit directly after the stop bit is captured.
- Overrun: a good stop-bit sample while rx_ready==1 and rx_clear==0 sets rx_overrun=1. rx_data is overwritten with the newer byte.
- Simultaneous rx_clear and good stop-bit sample: completion wins.
  - rx_ready=1, rx_data updated.
  - rx_overrun and rx_frame_error are cleared.
  - No overrun is flagged.
- Simultaneous rx_clear and bad stop-bit sample: rx_frame_error=1, rx_ready=0, rx_overrun=0.
- rx_clear never affects the FSM or counters, and never changes rx_data.
- Line held low (break): START and DATA proceed, then a frame error at STOP. IDLE waits for rx_s==1 before re-arming; no repeated frames are taken from a continuous low.
  - Implementation: an "armed" bit, set when rx_s==1 in IDLE; START is entered only when armed.
- All outputs are registered. There is no combinational path from rx_serial or rx_clear to outputs.

Test Plan:
- Bench uses CLKS_PER_BIT=16 throughout.
1. Reset with rx_serial=1 -> all outputs 0. Send byte 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> rx_ready=1 at cycle 2+8+144+1 (±1), rx_data=32'h000000A5, error flags 0.
2. Pulse rx_clear, then send 0x3C and 0x81 back-to-back with no idle gap -> rx_ready=1 and rx_data=0x3C after the first; rx_overrun=1 and rx_data=0x81 after the second. Pulse rx_clear -> all flags 0, rx_data still 0x81.
3. Send 0x55 with stop bit=0 -> rx_frame_error=1, rx_ready=0, rx_data keeps its previous value. Keep the line high, then send 0x0F -> rx_ready=1, rx_data=0x0F, rx_frame_error stays 1 until rx_clear.
4. Drive a 5-cycle low glitch on an idle line -> FSM returns to IDLE; no flag changes. A following byte 0xC3 is received correctly.
5. With rx_ready=1, time the rx_clear strobe to the exact cycle of the stop-bit sample of byte 0x7E -> rx_ready=1, rx_data=0x7E, rx_overrun=0.
6. Assert reset low for 1 cycle mid-DATA of byte 0xFF -> outputs 0 and no byte reported. The next byte 0x12 is received correctly.
